// File: rtl/button_conditioner.sv
// Multi-channel button front end: 2-flop sync, per-channel debounce FSM, edge pulses.
// Optional auto-repeat while held is built only when BUTTON_COND_REPEAT_EN is defined.
module button_conditioner #(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] pulse_out,
    output logic                any_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic RISE = (EDGE_MODE != 0);
    localparam logic FALL = (EDGE_MODE != 1);

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2 ||
        EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_param
        $error("button_conditioner: illegal parameter value");
    end

    typedef enum logic [1:0] {
        UP,
        CHK_DN,
        DOWN,
        CHK_UP
    } state_t;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t        st;
        logic [CW-1:0] cnt;
        logic          lvl;
        logic          pls;
        logic          s;
        logic          rpt_hit;

        assign s = sync2[i];

`ifdef BUTTON_COND_REPEAT_EN
        localparam int RW = $clog2(REPEAT_CYCLES);
        localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
        logic [RW-1:0] rpt;

        assign rpt_hit = (EDGE_MODE != 0) && (st == DOWN) && s &&
                         (rpt == RPT_LAST);

        // Cleared outside the pressed states, frozen in CHK_UP.
        always_ff @(posedge clk) begin
            if (reset) begin
                rpt <= '0;
            end else if (st == UP || st == CHK_DN) begin
                rpt <= '0;
            end else if (st == DOWN && s) begin
                rpt <= (rpt == RPT_LAST) ? '0 : rpt + RW'(1);
            end
        end
`else
        assign rpt_hit = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                st  <= UP;
                cnt <= '0;
                lvl <= 1'b0;
                pls <= 1'b0;
            end else begin
                pls <= 1'b0;
                unique case (st)
                    UP: begin
                        if (s) begin
                            cnt <= CNT_ONE;
                            if (DEBOUNCE_CYCLES == 1) begin
                                st  <= DOWN;
                                lvl <= 1'b1;
                                pls <= RISE;
                            end else begin
                                st <= CHK_DN;
                            end
                        end
                    end
                    CHK_DN: begin
                        if (!s) begin
                            st  <= UP;
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            st  <= DOWN;
                            lvl <= 1'b1;
                            pls <= RISE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    DOWN: begin
                        if (!s) begin
                            cnt <= CNT_ONE;
                            if (DEBOUNCE_CYCLES == 1) begin
                                st  <= UP;
                                lvl <= 1'b0;
                                pls <= FALL;
                            end else begin
                                st <= CHK_UP;
                            end
                        end else begin
                            pls <= rpt_hit;
                        end
                    end
                    CHK_UP: begin
                        if (s) begin
                            st  <= DOWN;
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            st  <= UP;
                            lvl <= 1'b0;
                            pls <= FALL;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                endcase
            end
        end

        assign level_out[i] = lvl;
        assign pulse_out[i] = pls;
    end

    assign any_pulse = |pulse_out;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: three instances (release, press, both) on shared stimulus.
// Expected pulses are queued per instance and matched by cycle in monitor processes.
module tb_button_conditioner;

    typedef struct {
        int         cyc;
        logic [1:0] p;
        logic [1:0] l;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] button;
    logic [1:0] l0, l1, l2, p0, p1, p2;
    logic       a0, a1, a2;

    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    int e0, e1, r0;
    ev_t q0[$], q1[$], q2[$];

    button_conditioner #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
                         .REPEAT_CYCLES(8)) d0 (
        .clk(clk), .reset(reset), .button_in(button),
        .level_out(l0), .pulse_out(p0), .any_pulse(a0));
    button_conditioner #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1),
                         .REPEAT_CYCLES(8)) d1 (
        .clk(clk), .reset(reset), .button_in(button),
        .level_out(l1), .pulse_out(p1), .any_pulse(a1));
    button_conditioner #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
                         .REPEAT_CYCLES(8)) d2 (
        .clk(clk), .reset(reset), .button_in(button),
        .level_out(l2), .pulse_out(p2), .any_pulse(a2));

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int id, input int c, input logic [1:0] p,
                        input logic [1:0] l);
        ev_t e;
        e.cyc = c;
        e.p = p;
        e.l = l;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic cmp_ev(input string nm, input ev_t e, input logic [1:0] p,
                          input logic [1:0] l, input logic a);
        ncmp++;
        if (e.cyc != cyc || e.p != p || e.l != l || a != 1'b1) begin
            nfail++;
            $display("FAIL %s pulse: got cyc=%0d pulse=%b level=%b any=%b, want cyc=%0d pulse=%b level=%b any=1",
                     nm, cyc, p, l, a, e.cyc, e.p, e.l);
        end
    endtask

    task automatic miss(input string nm, input ev_t e);
        ncmp++;
        nfail++;
        $display("FAIL %s missing pulse: got none, want pulse=%b at cyc=%0d",
                 nm, e.p, e.cyc);
    endtask

    task automatic unexp(input string nm, input logic [1:0] p, input logic a);
        ncmp++;
        nfail++;
        $display("FAIL %s unexpected pulse: got pulse=%b any=%b at cyc=%0d, want none",
                 nm, p, a, cyc);
    endtask

    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].cyc < cyc) miss("d0", q0.pop_front());
        if (|p0 || a0) begin
            if (q0.size() == 0) unexp("d0", p0, a0);
            else cmp_ev("d0", q0.pop_front(), p0, l0, a0);
        end
    end

    always @(negedge clk) begin
        while (q1.size() > 0 && q1[0].cyc < cyc) miss("d1", q1.pop_front());
        if (|p1 || a1) begin
            if (q1.size() == 0) unexp("d1", p1, a1);
            else cmp_ev("d1", q1.pop_front(), p1, l1, a1);
        end
    end

    always @(negedge clk) begin
        while (q2.size() > 0 && q2[0].cyc < cyc) miss("d2", q2.pop_front());
        if (|p2 || a2) begin
            if (q2.size() == 0) unexp("d2", p2, a2);
            else cmp_ev("d2", q2.pop_front(), p2, l2, a2);
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic lvl(input string nm, input logic [1:0] act,
                       input logic [1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s level: got %b want %b at cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic idle_chk(input string nm);
        logic [14:0] v;
        v = {l0, l1, l2, p0, p1, p2, a0, a1, a2};
        ncmp++;
        if (v !== '0) begin
            nfail++;
            $display("FAIL %s outputs: got %b want all zero at cyc=%0d", nm, v, cyc);
        end
    endtask

    task automatic qempty(input string nm, input int n);
        ncmp++;
        if (n != 0) begin
            nfail++;
            $display("FAIL %s queue: got %0d pending, want 0", nm, n);
        end
    endtask

    initial begin
        button = 2'b00;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        idle_chk("reset");
        reset = 1'b0;
        @(negedge clk);
        idle_chk("post_reset");

        // single press and release on channel 0
        wait_to(5);
        button = 2'b01;
        e0 = cyc + 1;
        push(1, e0 + 5, 2'b01, 2'b01);
        push(2, e0 + 5, 2'b01, 2'b01);
        wait_to(e0 + 4);
        lvl("press_pre", l1, 2'b00);
        wait_to(e0 + 5);
        lvl("press_d1", l1, 2'b01);
        lvl("press_d0", l0, 2'b01);
        wait_to(e0 + 9);
        button = 2'b00;
        e1 = cyc + 1;
        push(0, e1 + 5, 2'b01, 2'b00);
        push(2, e1 + 5, 2'b01, 2'b00);
        wait_to(e1 + 4);
        lvl("rel_pre", l0, 2'b01);
        wait_to(e1 + 5);
        lvl("rel_d0", l0, 2'b00);

        // short excursion and bounce
        wait_to(e1 + 12);
        button = 2'b01;
        e0 = cyc + 1;
        wait_to(e0 + 2);
        button = 2'b00;
        wait_to(e0 + 8);
        lvl("short_d1", l1, 2'b00);
        button = 2'b01;
        @(negedge clk);
        button = 2'b00;
        @(negedge clk);
        button = 2'b01;
        @(negedge clk);
        button = 2'b00;
        repeat (8) @(negedge clk);
        lvl("bounce_d2", l2, 2'b00);

        // both channels together, then reset while held
        button = 2'b11;
        e0 = cyc + 1;
        push(1, e0 + 5, 2'b11, 2'b11);
        push(2, e0 + 5, 2'b11, 2'b11);
        wait_to(e0 + 5);
        lvl("both_d1", l1, 2'b11);
        wait_to(e0 + 7);
        reset = 1'b1;
        wait_to(e0 + 8);
        idle_chk("reset_mid");
        wait_to(e0 + 9);
        reset = 1'b0;
        r0 = cyc + 1;
        push(1, r0 + 5, 2'b11, 2'b11);
        push(2, r0 + 5, 2'b11, 2'b11);
        wait_to(r0 + 4);
        lvl("held_pre", l1, 2'b00);
        wait_to(r0 + 5);
        lvl("held_d1", l1, 2'b11);
        wait_to(r0 + 9);
        button = 2'b00;
        e1 = cyc + 1;
        push(0, e1 + 5, 2'b11, 2'b00);
        push(2, e1 + 5, 2'b11, 2'b00);
        wait_to(e1 + 5);
        lvl("both_rel_d2", l2, 2'b00);

        // long hold on channel 1
        wait_to(e1 + 12);
        button = 2'b10;
        e0 = cyc + 1;
        push(1, e0 + 5, 2'b10, 2'b10);
        push(2, e0 + 5, 2'b10, 2'b10);
`ifdef BUTTON_COND_REPEAT_EN
        for (int k = 1; k <= 3; k++) begin
            push(1, e0 + 5 + 8 * k, 2'b10, 2'b10);
            push(2, e0 + 5 + 8 * k, 2'b10, 2'b10);
        end
`endif
        wait_to(e0 + 20);
        lvl("hold_d0", l0, 2'b10);
        wait_to(e0 + 29);
        button = 2'b00;
        e1 = cyc + 1;
        push(0, e1 + 5, 2'b10, 2'b00);
        push(2, e1 + 5, 2'b10, 2'b00);
        wait_to(e1 + 15);
        lvl("end_d1", l1, 2'b00);
        qempty("d0", q0.size());
        qempty("d1", q1.size());
        qempty("d2", q2.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
